// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counter plus pipeline-aligned VGA sync, data-enable and pixel outputs.
// Latency: h_sync/v_sync/de/rgb follow the counter coordinate by PIPE_DLY+1 ce cycles.
// Backpressure: none; every register advances only on ce=1 and holds otherwise.
// Build option: define VTG_TEST_PATTERN_EN to include the 8-bar colour pattern selected by pattern_en.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 29,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int PIPE_DLY = 2,
   parameter int CW       = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ce,
   input  logic            pattern_en,
   input  logic [3*CW-1:0] rgb_in,
   output logic [9:0]      px_x,
   output logic [9:0]      px_y,
   output logic            px_req,
   output logic            line_start,
   output logic            frame_start,
   output logic            h_sync,
   output logic            v_sync,
   output logic            de,
   output logic [CW-1:0]   red,
   output logic [CW-1:0]   green,
   output logic [CW-1:0]   blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
   // 11-bit compare constants so a sync region ending exactly at 1024 still fits
   localparam logic [10:0] H_ACT     = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT     = 11'(V_ACTIVE);
   localparam logic [10:0] H_SYNC_B  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_SYNC_E  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_SYNC_B  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_SYNC_E  = 11'(V_ACTIVE + V_FP + V_SYNC);

   // One pipeline stage: sync flags are carried active-high, polarity applied at the output
   typedef struct packed {
`ifdef VTG_TEST_PATTERN_EN
      logic [9:0] x;
`endif
      logic       hs;
      logic       vs;
      logic       de;
   } stage_t;

   logic [9:0]  hc;
   logic [9:0]  vc;
   logic [10:0] hc_w;
   logic [10:0] vc_w;
   logic        hs_raw;
   logic        vs_raw;
   stage_t      cur;
   stage_t      dly;

   assign hc_w = {1'b0, hc};
   assign vc_w = {1'b0, vc};

   // Raster counter: hc wraps every line and carries into vc
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hc <= '0;
         vc <= '0;
      end else if (ce) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
         end else begin
            hc <= hc + 10'd1;
         end
      end
   end

   assign px_x        = hc;
   assign px_y        = vc;
   assign px_req      = (hc_w < H_ACT) && (vc_w < V_ACT);
   assign line_start  = ce && (hc == 10'd0);
   assign frame_start = ce && (hc == 10'd0) && (vc == 10'd0);
   assign hs_raw      = (hc_w >= H_SYNC_B) && (hc_w < H_SYNC_E);
   assign vs_raw      = (vc_w >= V_SYNC_B) && (vc_w < V_SYNC_E);

   // Undelayed timing flags for the current counter position
   always_comb begin
      cur = '0;
`ifdef VTG_TEST_PATTERN_EN
      cur.x = hc;
`endif
      cur.hs = hs_raw;
      cur.vs = vs_raw;
      cur.de = px_req;
   end

   // PIPE_DLY ce-gated stages matching the pixel source latency; none when PIPE_DLY is 0
   generate
      if (PIPE_DLY == 0) begin : g_nodly
         assign dly = cur;
      end else begin : g_dly
         for (genvar i = 0; i < PIPE_DLY; i++) begin : g_stage
            stage_t d;
            stage_t q;
            if (i == 0) begin : g_first
               assign d = cur;
            end else begin : g_next
               assign d = g_stage[i-1].q;
            end
            // One delay stage; reset value is the inactive (outside sync, blanked) state
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  q <= '0;
               end else if (ce) begin
                  q <= d;
               end
            end
         end
         assign dly = g_stage[PIPE_DLY-1].q;
      end
   endgenerate

`ifdef VTG_TEST_PATTERN_EN
   localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
   logic [2:0] bar;
   assign bar = 3'(dly.x / BAR_W);
`else
   logic unused_pattern_en;
   assign unused_pattern_en = pattern_en;
`endif

   // Output registers: apply sync polarity, blank pixels outside the active area
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_sync <= ~H_POL;
         v_sync <= ~V_POL;
         de     <= 1'b0;
         red    <= '0;
         green  <= '0;
         blue   <= '0;
      end else if (ce) begin
         h_sync <= dly.hs ? H_POL : ~H_POL;
         v_sync <= dly.vs ? V_POL : ~V_POL;
         de     <= dly.de;
         if (dly.de) begin
            red   <= rgb_in[3*CW-1:2*CW];
            green <= rgb_in[2*CW-1:CW];
            blue  <= rgb_in[CW-1:0];
`ifdef VTG_TEST_PATTERN_EN
            if (pattern_en) begin
               red   <= {CW{bar[2]}};
               green <= {CW{bar[1]}};
               blue  <= {CW{bar[0]}};
            end
`endif
         end else begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen on a reduced raster geometry.
// Main instance: active-low syncs, PIPE_DLY=2; second instance: active-high syncs, PIPE_DLY=0.
// A two-stage pixel source feeds {x[5:0], y[5:0], 6'h2A} so rgb alignment is observable.
`timescale 1ns/1ps
module tb_vga_timing_gen;

   localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = 80;
   localparam int VA = 8,  VF = 2, VS = 2, VB = 3, VT = 15;
   localparam int CW = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ce;
   logic        pattern_en;
   logic [17:0] rgb_in;
   logic [17:0] src_s1;

   logic [9:0]  px_x, px_y;
   logic        px_req, line_start, frame_start, h_sync, v_sync, de;
   logic [5:0]  red, green, blue;

   logic [9:0]  px_x_p, px_y_p;
   logic        px_req_p, line_start_p, frame_start_p, h_sync_p, v_sync_p, de_p;
   logic [5:0]  red_p, green_p, blue_p;

   int cmp_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;

   // reference raster model: current coordinate and coordinates of the last three ce cycles
   int ehc, evc;
   int hx [1:3];
   int hy [1:3];
   bit hv [1:3];

   // measurements filled by run_checked
   int hs_period, hs_low, vs_period, vs_low, de_cnt, hs0_high, req_rise, de0_rise;
   logic [17:0] cap0, cap1, cap7;

   always #5 clk = ~clk;

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(2), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ce(ce), .pattern_en(pattern_en), .rgb_in(rgb_in),
      .px_x(px_x), .px_y(px_y), .px_req(px_req), .line_start(line_start),
      .frame_start(frame_start), .h_sync(h_sync), .v_sync(v_sync), .de(de),
      .red(red), .green(green), .blue(blue));

   vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                    .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(0), .CW(CW)) dut_p (
      .clk(clk), .rst_n(rst_n), .ce(ce), .pattern_en(pattern_en), .rgb_in(rgb_in),
      .px_x(px_x_p), .px_y(px_y_p), .px_req(px_req_p), .line_start(line_start_p),
      .frame_start(frame_start_p), .h_sync(h_sync_p), .v_sync(v_sync_p), .de(de_p),
      .red(red_p), .green(green_p), .blue(blue_p));

   // pixel source with two ce cycles of latency from coordinate to rgb_in
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_s1 <= '0;
         rgb_in <= '0;
      end else if (ce) begin
         src_s1 <= {px_x[5:0], px_y[5:0], 6'h2A};
         rgb_in <= src_s1;
      end
   end

   task automatic model_reset();
      ehc = 0;
      evc = 0;
      for (int i = 1; i <= 3; i++) begin
         hx[i] = 0; hy[i] = 0; hv[i] = 1'b0;
      end
   endtask

   // runs ncyc clocks comparing every output against the raster model each cycle
   task automatic run_checked(input int ncyc, input bit pat, input bit tog);
      bit ce_edge, exp_de, exp_hs, exp_vs, exp_de0, exp_hs0, exp_vs0;
      bit prev_hs, prev_vs, prev_req, prev_de0;
      int last_hf, last_vf;
      logic [17:0] exp_rgb, got_rgb;
      logic [2:0] b;
      hs_period = -1; hs_low = -1; vs_period = -1; vs_low = -1;
      de_cnt = 0; hs0_high = 0; req_rise = -1; de0_rise = -1;
      last_hf = -1; last_vf = -1;
      prev_hs = h_sync; prev_vs = v_sync; prev_req = px_req; prev_de0 = de_p;
      for (int n = 0; n < ncyc; n++) begin
         @(posedge clk);
         #1;
         cyc++;
         ce_edge = ce;
         if (ce_edge) begin
            hx[3] = hx[2]; hy[3] = hy[2]; hv[3] = hv[2];
            hx[2] = hx[1]; hy[2] = hy[1]; hv[2] = hv[1];
            hx[1] = ehc;   hy[1] = evc;   hv[1] = 1'b1;
            if (ehc == HT - 1) begin
               ehc = 0;
               evc = (evc == VT - 1) ? 0 : evc + 1;
            end else begin
               ehc++;
            end
         end
         ce = tog ? ~ce : 1'b1;
         #1;
         exp_de  = hv[3] && hx[3] < HA && hy[3] < VA;
         exp_hs  = !(hv[3] && hx[3] >= HA + HF && hx[3] < HA + HF + HS);
         exp_vs  = !(hv[3] && hy[3] >= VA + VF && hy[3] < VA + VF + VS);
         exp_de0 = hv[1] && hx[1] < HA && hy[1] < VA;
         exp_hs0 = hv[1] && hx[1] >= HA + HF && hx[1] < HA + HF + HS;
         exp_vs0 = hv[1] && hy[1] >= VA + VF && hy[1] < VA + VF + VS;
         exp_rgb = '0;
         if (exp_de) begin
            exp_rgb = {6'(hx[3]), 6'(hy[3]), 6'h2A};
`ifdef VTG_TEST_PATTERN_EN
            if (pat) begin
               b = 3'(hx[3] / (HA / 8));
               exp_rgb = {{6{b[2]}}, {6{b[1]}}, {6{b[0]}}};
            end
`endif
         end
         got_rgb = {red, green, blue};

         cmp_cnt++;
         if (px_x !== 10'(ehc) || px_y !== 10'(evc)) begin
            err_cnt++;
            $display("FAIL coord @%0d: got x=%0d y=%0d expected x=%0d y=%0d", cyc, px_x, px_y, ehc, evc);
         end
         cmp_cnt++;
         if (px_req !== (ehc < HA && evc < VA)) begin
            err_cnt++;
            $display("FAIL px_req @%0d: got %b expected %b", cyc, px_req, (ehc < HA && evc < VA));
         end
         cmp_cnt++;
         if (line_start !== (ce && ehc == 0) || frame_start !== (ce && ehc == 0 && evc == 0)) begin
            err_cnt++;
            $display("FAIL strobes @%0d: got ls=%b fs=%b expected ls=%b fs=%b", cyc, line_start,
                     frame_start, (ce && ehc == 0), (ce && ehc == 0 && evc == 0));
         end
         cmp_cnt++;
         if (h_sync !== exp_hs || v_sync !== exp_vs || de !== exp_de) begin
            err_cnt++;
            $display("FAIL timing @%0d: got hs=%b vs=%b de=%b expected hs=%b vs=%b de=%b", cyc,
                     h_sync, v_sync, de, exp_hs, exp_vs, exp_de);
         end
         cmp_cnt++;
         if (got_rgb !== exp_rgb) begin
            err_cnt++;
            $display("FAIL rgb @%0d: got %h expected %h", cyc, got_rgb, exp_rgb);
         end
         cmp_cnt++;
         if (h_sync_p !== exp_hs0 || v_sync_p !== exp_vs0 || de_p !== exp_de0) begin
            err_cnt++;
            $display("FAIL timing_pos_pol @%0d: got hs=%b vs=%b de=%b expected hs=%b vs=%b de=%b", cyc,
                     h_sync_p, v_sync_p, de_p, exp_hs0, exp_vs0, exp_de0);
         end

         if (pat && exp_de && hy[3] == 1) begin
            if (hx[3] == 0)      cap0 = got_rgb;
            if (hx[3] == HA / 8) cap1 = got_rgb;
            if (hx[3] == HA - 1) cap7 = got_rgb;
         end
         if (prev_hs && !h_sync) begin
            if (last_hf >= 0) hs_period = cyc - last_hf;
            last_hf = cyc;
         end
         if (!prev_hs && h_sync && last_hf >= 0) hs_low = cyc - last_hf;
         if (prev_vs && !v_sync) begin
            if (last_vf >= 0) vs_period = cyc - last_vf;
            last_vf = cyc;
         end
         if (!prev_vs && v_sync && last_vf >= 0) vs_low = cyc - last_vf;
         if (ce_edge && de) de_cnt++;
         if (h_sync_p) hs0_high++;
         if (!prev_req && px_req) req_rise = cyc;
         if (!prev_de0 && de_p) de0_rise = cyc;
         prev_hs = h_sync; prev_vs = v_sync; prev_req = px_req; prev_de0 = de_p;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ce = 1'b1;
      pattern_en = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      cmp_cnt++;
      if (px_x !== 10'd0 || px_y !== 10'd0) begin
         err_cnt++; $display("FAIL reset_coord: got x=%0d y=%0d expected 0 0", px_x, px_y);
      end
      cmp_cnt++;
      if (h_sync !== 1'b1 || v_sync !== 1'b1) begin
         err_cnt++; $display("FAIL reset_sync: got hs=%b vs=%b expected 1 1", h_sync, v_sync);
      end
      cmp_cnt++;
      if (de !== 1'b0 || {red, green, blue} !== 18'h0) begin
         err_cnt++; $display("FAIL reset_de_rgb: got de=%b rgb=%h expected 0 0", de, {red, green, blue});
      end
      cmp_cnt++;
      if (h_sync_p !== 1'b0 || v_sync_p !== 1'b0 || de_p !== 1'b0) begin
         err_cnt++; $display("FAIL reset_pos_pol: got hs=%b vs=%b de=%b expected 0 0 0", h_sync_p, v_sync_p, de_p);
      end
      cmp_cnt++;
      if (px_req !== 1'b1 || line_start !== 1'b1 || frame_start !== 1'b1) begin
         err_cnt++; $display("FAIL reset_strobes: got req=%b ls=%b fs=%b expected 1 1 1", px_req, line_start, frame_start);
      end
      ce = 1'b0;
      #1;
      cmp_cnt++;
      if (line_start !== 1'b0 || frame_start !== 1'b0) begin
         err_cnt++; $display("FAIL strobe_ce_low: got ls=%b fs=%b expected 0 0", line_start, frame_start);
      end
      ce = 1'b1;
   endtask

   task automatic test_release();
      rst_n = 1'b1;
      #1;
      cmp_cnt++;
      if (line_start !== 1'b1 || frame_start !== 1'b1) begin
         err_cnt++; $display("FAIL release_strobes: got ls=%b fs=%b expected 1 1", line_start, frame_start);
      end
      run_checked(1, 1'b0, 1'b0);
      cmp_cnt++;
      if (px_x !== 10'd1 || px_y !== 10'd0) begin
         err_cnt++; $display("FAIL release_first_ce: got x=%0d y=%0d expected 1 0", px_x, px_y);
      end
   endtask

   task automatic test_timing();
      run_checked(2 * HT * VT, 1'b0, 1'b0);
      cmp_cnt++;
      if (hs_period !== HT || hs_low !== HS) begin
         err_cnt++; $display("FAIL hsync_shape: got period=%0d low=%0d expected %0d %0d", hs_period, hs_low, HT, HS);
      end
      cmp_cnt++;
      if (vs_period !== HT * VT || vs_low !== VS * HT) begin
         err_cnt++; $display("FAIL vsync_shape: got period=%0d low=%0d expected %0d %0d", vs_period, vs_low, HT * VT, VS * HT);
      end
      cmp_cnt++;
      if (de_cnt !== 2 * HA * VA) begin
         err_cnt++; $display("FAIL de_count: got %0d expected %0d", de_cnt, 2 * HA * VA);
      end
   endtask

   task automatic test_ce_toggle();
      run_checked(4 * HT * VT, 1'b0, 1'b1);
      ce = 1'b1;
      cmp_cnt++;
      if (hs_period !== 2 * HT || hs_low !== 2 * HS) begin
         err_cnt++; $display("FAIL ce_hsync_shape: got period=%0d low=%0d expected %0d %0d", hs_period, hs_low, 2 * HT, 2 * HS);
      end
      cmp_cnt++;
      if (vs_period !== 2 * HT * VT) begin
         err_cnt++; $display("FAIL ce_frame_period: got %0d expected %0d", vs_period, 2 * HT * VT);
      end
      cmp_cnt++;
      if (de_cnt !== 2 * HA * VA) begin
         err_cnt++; $display("FAIL ce_de_count: got %0d expected %0d", de_cnt, 2 * HA * VA);
      end
   endtask

   task automatic test_polarity();
      run_checked(2 * HT, 1'b0, 1'b0);
      cmp_cnt++;
      if (hs0_high !== 2 * HS) begin
         err_cnt++; $display("FAIL pos_hsync_width: got %0d expected %0d", hs0_high, 2 * HS);
      end
      cmp_cnt++;
      if (de0_rise - req_rise !== 1) begin
         err_cnt++; $display("FAIL de_after_req: got %0d expected 1", de0_rise - req_rise);
      end
   endtask

   task automatic test_pattern();
      cap0 = 'x; cap1 = 'x; cap7 = 'x;
      pattern_en = 1'b1;
      run_checked(HT * VT, 1'b1, 1'b0);
      pattern_en = 1'b0;
`ifdef VTG_TEST_PATTERN_EN
      cmp_cnt++;
      if (cap0 !== 18'h00000) begin
         err_cnt++; $display("FAIL bar0_black: got %h expected 00000", cap0);
      end
      cmp_cnt++;
      if (cap1 !== 18'h0003F) begin
         err_cnt++; $display("FAIL bar1_blue: got %h expected 0003f", cap1);
      end
      cmp_cnt++;
      if (cap7 !== 18'h3FFFF) begin
         err_cnt++; $display("FAIL bar7_white: got %h expected 3ffff", cap7);
      end
`else
      cmp_cnt++;
      if (cap0 !== {6'd0, 6'd1, 6'h2A}) begin
         err_cnt++; $display("FAIL nopat_x0: got %h expected %h", cap0, {6'd0, 6'd1, 6'h2A});
      end
      cmp_cnt++;
      if (cap1 !== {6'd8, 6'd1, 6'h2A}) begin
         err_cnt++; $display("FAIL nopat_x8: got %h expected %h", cap1, {6'd8, 6'd1, 6'h2A});
      end
      cmp_cnt++;
      if (cap7 !== {6'd63, 6'd1, 6'h2A}) begin
         err_cnt++; $display("FAIL nopat_x63: got %h expected %h", cap7, {6'd63, 6'd1, 6'h2A});
      end
`endif
   endtask

   task automatic test_async_reset();
      int guard = 0;
      while (!(ehc == 40 && evc == 5) && guard < 3000) begin
         run_checked(1, 1'b0, 1'b0);
         guard++;
      end
      cmp_cnt++;
      if (guard >= 3000) begin
         err_cnt++; $display("FAIL async_reach_point: got guard=%0d expected < 3000", guard);
      end
      cmp_cnt++;
      if (de !== 1'b1) begin
         err_cnt++; $display("FAIL de_before_reset: got %b expected 1", de);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp_cnt++;
      if (px_x !== 10'd0 || px_y !== 10'd0) begin
         err_cnt++; $display("FAIL async_coord: got x=%0d y=%0d expected 0 0", px_x, px_y);
      end
      cmp_cnt++;
      if (h_sync !== 1'b1 || v_sync !== 1'b1 || de !== 1'b0 || {red, green, blue} !== 18'h0) begin
         err_cnt++; $display("FAIL async_outputs: got hs=%b vs=%b de=%b rgb=%h expected 1 1 0 0",
                             h_sync, v_sync, de, {red, green, blue});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      cmp_cnt++;
      if (frame_start !== 1'b1) begin
         err_cnt++; $display("FAIL async_frame_start: got %b expected 1", frame_start);
      end
      run_checked(1, 1'b0, 1'b0);
      cmp_cnt++;
      if (px_x !== 10'd1) begin
         err_cnt++; $display("FAIL async_first_ce: got x=%0d expected 1", px_x);
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_timing();
      test_ce_toggle();
      test_polarity();
      test_pattern();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, meaning horizontal front porch, sync and back porch in pixels; H_TOTAL = sum of all four = 800.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 29, meaning the vertical equivalents in lines; V_TOTAL = 521.
REQ-004 SHALL have parameters H_POL 0 and V_POL 0, meaning sync active level (0 = active-low).
REQ-005 SHALL have parameter PIPE_DLY, default 2, range 0-7, meaning pixel-source latency in ce cycles.
REQ-006 SHALL have parameter CW, default 6, meaning bits per colour channel.
REQ-007 clk  in  1  pixel clock; the single clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 ce  in  1  pixel clock enable; all state advances only on clk rising edges with ce=1.
REQ-010 pattern_en  in  1  selects the built-in test pattern (REQ-031).
REQ-011 rgb_in  in  3*CW  pixel data from the source, {r,g,b}.
REQ-012 px_x, px_y  out  10 each  current counter coordinate.
REQ-013 px_req  out  1  high when the counter is inside the active area.
REQ-014 line_start, frame_start  out  1 each  counter-aligned strobes.
REQ-015 h_sync, v_sync, de  out  1 each  registered, pipeline-aligned timing outputs.
REQ-016 red, green, blue  out  CW each  registered pixel outputs.

Function
REQ-017 hc SHALL count 0..H_TOTAL-1, advancing on each ce; at H_TOTAL-1 it SHALL wrap to 0 and advance vc, which counts 0..V_TOTAL-1 and wraps to 0.
REQ-018 Region order SHALL be active, front porch, sync, back porch: h sync is active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC; v sync is defined the same way on vc.
REQ-019 px_x SHALL equal hc and px_y SHALL equal vc, both combinational from the counter registers.
REQ-020 px_req SHALL be asserted exactly when hc < H_ACTIVE and vc < V_ACTIVE.
REQ-021 line_start SHALL equal ce and hc==0; frame_start SHALL equal ce and hc==0 and vc==0.
REQ-022 Undelayed hsync, vsync, active and px_x SHALL each pass through a PIPE_DLY-stage shift register that advances only on ce.
REQ-023 On each ce, the output registers SHALL load h_sync, v_sync and de from the delayed values; for a coordinate presented at ce-cycle k, these outputs SHALL appear after the edge of ce-cycle k+PIPE_DLY.
REQ-024 On the same edge as REQ-023, red/green/blue SHALL load rgb_in when delayed de=1, and SHALL load 0 otherwise.
REQ-025 With ce=0, all registers including the pipeline SHALL hold their values.
REQ-026 With PIPE_DLY=0, no delay stages SHALL exist, and outputs SHALL lag the counter by exactly one ce cycle.
REQ-027 Parameters giving H_TOTAL > 1024 or V_TOTAL > 1024 are illegal; behaviour in that case is undefined.

Reset
REQ-028 While rst_n=0, hc and vc SHALL be 0, every delay stage SHALL hold inactive values, de SHALL be 0, rgb SHALL be 0, and h_sync/v_sync SHALL sit at their inactive levels (~H_POL, ~V_POL).
REQ-029 Assertion of rst_n mid-frame SHALL take effect immediately (asynchronously); the first ce after deassertion SHALL give hc=1 with line_start and frame_start having been high during the cycle before it.
REQ-030 Reset deassertion SHALL be taken synchronously to clk by the integrating top; the block itself contains no synchroniser.

Configuration
REQ-031 With VTG_TEST_PATTERN_EN defined and pattern_en=1, active-area rgb SHALL be 8 vertical colour bars selected by delayed px_x/(H_ACTIVE/8); bar index b SHALL give red all-ones if b[2], green all-ones if b[1], blue all-ones if b[0], and rgb_in is ignored.
REQ-032 With VTG_TEST_PATTERN_EN undefined, the pattern logic SHALL be absent, pattern_en SHALL be ignored, and timing SHALL be identical.

Verification
REQ-033 Defaults, ce=1, run 2 frames -> exactly 800 clk between h_sync falling edges; h_sync low for 96 clk; 521 lines per frame; v_sync low for 2 lines; 307200 de=1 cycles per frame.
REQ-034 rgb_in = {px_x[5:0], px_y[5:0], 6'h2A} fed through a 2-cycle-latency model -> at each de=1 output, red/green equal the coordinate latched 2 ce earlier; red=green=blue=0 whenever de=0.
REQ-035 ce toggling 1,0,1,0 -> line period of 1600 clk, outputs stable on ce=0 cycles, same 307200 active pixels per frame.
REQ-036 rst_n pulsed low at hc=300, vc=200, asynchronous to the edge -> immediately hc=0, vc=0, h_sync=v_sync=1, de=0, rgb=0; after release frame_start fires on the first ce.
REQ-037 H_POL=1, V_POL=1, PIPE_DLY=0 -> syncs high-active, de rises one clk after px_req rises.
REQ-038 VTG_TEST_PATTERN_EN defined, pattern_en=1 -> output x=0..79 is black, x=80..159 is blue=6'h3F, x=560..639 is white; with the macro undefined, the output follows rgb_in.
